// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } link_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, tick marks the last cycle.
module bit_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits, optional even parity, stop bit.
// state     | meaning
// ST_IDLE   | line high, ready for a word
// ST_START  | start bit (0)
// ST_DATA   | data bits in LSB_FIRST order
// ST_PARITY | even parity of the accepted word
// ST_STOP   | stop bit (1), then done pulse on return to idle
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  link_state_t       state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic              par;
  logic              tick;
  logic              accept;
  logic              out_bit;
  logic [DATA_W-1:0] shifted;

  assign accept  = (state == ST_IDLE) && tx_valid && tx_ready;
  assign out_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_W-1];
  assign shifted = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

  bit_tick_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state != ST_IDLE),
    .tick  (tick)
  );

  // The outgoing bit is always taken from the same end of shreg; the register
  // shifts as each bit is launched so the next one is already in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sdo      <= IDLE_LEVEL;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      bitcnt   <= '0;
      par      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg    <= tx_data;
            par      <= ^tx_data;
            bitcnt   <= '0;
            state    <= ST_START;
            sdo      <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            sdo   <= out_bit;
            shreg <= shifted;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bitcnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                sdo   <= par;
              end else begin
                state <= ST_STOP;
                sdo   <= 1'b1;
              end
            end else begin
              bitcnt <= bitcnt + BW'(1);
              sdo    <= out_bit;
              shreg  <= shifted;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            sdo   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state    <= ST_IDLE;
            sdo      <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          sdo      <= IDLE_LEVEL;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter; the transmit end of the team's single-wire serial link.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Emits a framed bit stream on sdo: start bit, data bits, optional even parity, stop bit. Each bit is held for CLKS_PER_BIT clocks.
- Sits between a parallel producer and the link's SIPO receiver.

Parameters:
- DATA_W, 8: data word width, ≥1.
- CLKS_PER_BIT, 4: clocks per serial bit, ≥1 (1 is legal).
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
- LSB_FIRST, 1: 1 shifts the LSB out first; 0 shifts the MSB out first.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_W  word to send; sampled only at acceptance.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  block can accept; high only in IDLE.
- sdo  out  1  serial data out, registered; idle level 1.
- busy  out  1  frame in progress (any state except IDLE).
- done  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset: rst=1 at an edge forces the following after that edge:
  - state=IDLE, sdo=1, tx_ready=1, busy=0, done=0;
  - bit counter and clock counter = 0; shift register = 0.
  - rst takes priority over everything else.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Acceptance:
  - Occurs at an edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register; state becomes START; sdo=0 after that edge.
  - tx_valid while not ready is ignored; no queueing.
  - tx_data changes during a frame have no effect.
- Bit timing:
  - Each state holds sdo constant for exactly CLKS_PER_BIT cycles.
  - The clock counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances.
- DATA:
  - DATA_W bits, with order set by LSB_FIRST.
  - The bit counter counts 0..DATA_W-1; leave DATA when the counter reaches DATA_W-1 and the clock counter wraps.
- PARITY: sdo = XOR of all latched data bits (even parity).
- STOP: sdo=1.
- Frame length and end of frame:
  - N = (2 + DATA_W + PARITY_EN) bits.
  - If acceptance is at edge k, the edge at k + N*CLKS_PER_BIT returns the block to IDLE.
  - For the cycle after that edge: done=1, tx_ready=1, busy=0.
  - done is deasserted after one cycle regardless of tx_valid.
- Back-to-back frames:
  - The earliest next acceptance is the edge ending the done cycle.
  - This gives a minimum of one idle cycle (sdo=1) between frames.
- Reset mid-frame:
  - The frame is abandoned; sdo returns to 1 after the reset edge.
  - done is not pulsed.
  - A tx_valid present during reset is not accepted until after rst deasserts.
- Width rules:
  - Bit counter width = clog2(DATA_W)+1.
  - Clock counter width = clog2(CLKS_PER_BIT)+1.
  - No overflow is reachable.

Decomposition:
- Shared package serial_link_pkg holds:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3-bit);
  - constant IDLE_LEVEL=1'b1.
  - The matching receiver uses the same package.
- One natural sub-module, bit_tick_counter:
  - parameterised on CLKS_PER_BIT;
  - inputs clk, rst, clear, enable; output tick (high on the last cycle of a bit period).
  - The FSM advances state on tick.

Test Plan:
- Basic frame: DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1, LSB_FIRST=1; send 0xA5 -> sdo sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit 4 cycles. done pulses exactly 44 cycles after the acceptance edge; tx_ready=0 throughout the frame.
- MSB-first, no parity: LSB_FIRST=0, PARITY_EN=0, CLKS_PER_BIT=1; send 0x80 -> sdo = 0,1,0,0,0,0,0,0,0,1. done 10 cycles after acceptance.
- Odd parity data: send 0x07 (3 ones) -> parity bit 1; send 0x00 -> parity bit 0, stop bit 1.
- Back-to-back: hold tx_valid=1 with 0x3C then 0xC3 -> second acceptance on the edge ending the done cycle; exactly one idle-high cycle between stop bit and next start bit; both frames bit-exact.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 of 0xFF -> sdo=1, tx_ready=1, busy=0 after the reset edge; no done pulse; the next word 0x55 is sent cleanly.
- Handshake hygiene:
  - Toggle tx_data every cycle during a frame -> the transmitted word equals the value at acceptance.
  - Assert tx_valid while busy -> no acceptance and no frame corruption.
